// File: rtl/slave_burst_control_pkg.sv
// Shared definitions for the chip2chip slave burst controller:
// FSM state encoding and width helper functions.
package slave_burst_control_pkg;

  // Handshake FSM states (2-bit encoding shared across the chip2chip family).
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_NOTICE = 2'd1,
    ST_ACK    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

  // Counter width able to hold values 0..v-1, never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned v);
    return (clog2(v) == 0) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/slave_burst_control_cycle_counter.sv
// Terminal-count cycle counter.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : restart counting from zero (dominates enable)
//   enable    : count this cycle
//   expire_c  : combinational pulse in the LEN-th enabled cycle after clear
module slave_burst_control_cycle_counter
  import slave_burst_control_pkg::*;
#(
  parameter int unsigned LEN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  localparam int unsigned CNT_W = width_of(LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  logic [CNT_W-1:0] count;

  // Up-counter that parks at LAST instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire_c = enable & (count == LAST);

endmodule

// File: rtl/slave_burst_control.sv
// Chip2chip slave handshake with burst capture.
// Accepts a request, shows a notice window, raises ack, then captures a
// BURST_LEN-word burst (one word per synchronised valid rising edge) into a
// shadow buffer that is committed atomically to data on the last word.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   request      : master request (asynchronous)
//   valid        : master data strobe (asynchronous)
//   data_in      : master data word, stable while valid is high
//   ack          : registered acknowledge to master
//   notice       : registered notice indicator
//   data         : last committed burst, word 0 in the LSBs
//   done         : one-cycle pulse on burst commit
//   word_idx     : words received in the current burst
//   timeout_err  : sticky ack-timeout flag, cleared by the next request
module slave_burst_control
  import slave_burst_control_pkg::*;
#(
  parameter int unsigned DATA_W         = 3,
  parameter int unsigned BURST_LEN      = 4,
  parameter int unsigned NOTICE_CYCLES  = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 200_000_000,
  localparam int unsigned BUS_W = DATA_W * BURST_LEN,
  localparam int unsigned IDX_W = width_of(BURST_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request,
  input  logic              valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack,
  output logic              notice,
  output logic [BUS_W-1:0]  data,
  output logic              done,
  output logic [IDX_W-1:0]  word_idx,
  output logic              timeout_err
);

  logic              req_s1, req_s2;
  logic              vld_s1, vld_s2, vld_prev;
  logic [DATA_W-1:0] din_s1, din_s2;
  logic              valid_edge_c;

  state_t            state, state_nxt;
  logic              start_c, capture_c, commit_c, tmo_set_c;
  logic              last_c;
  logic              notice_expire_c, tmo_expire_c;

  logic [BUS_W-1:0]  shadow, shadow_nxt;

  // Two-flop synchronisers; data rides alongside valid so both arrive together.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_s1   <= 1'b0;
      req_s2   <= 1'b0;
      vld_s1   <= 1'b0;
      vld_s2   <= 1'b0;
      vld_prev <= 1'b0;
      din_s1   <= '0;
      din_s2   <= '0;
    end else begin
      req_s1   <= request;
      req_s2   <= req_s1;
      vld_s1   <= valid;
      vld_s2   <= vld_s1;
      vld_prev <= vld_s2;
      din_s1   <= data_in;
      din_s2   <= din_s1;
    end
  end

  assign valid_edge_c = vld_s2 & ~vld_prev;
  assign last_c       = (word_idx == IDX_W'(BURST_LEN - 1));

  // Notice window length.
  slave_burst_control_cycle_counter #(
    .LEN (NOTICE_CYCLES)
  ) u_notice_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (state != ST_NOTICE),
    .enable   (state == ST_NOTICE),
    .expire_c (notice_expire_c)
  );

  // Ack idle timeout, restarted on ACK entry and on every accepted valid edge.
  if (TIMEOUT_CYCLES != 0) begin : g_tmo
    logic tmo_clear_c;
    assign tmo_clear_c = (state != ST_ACK) | valid_edge_c;

    slave_burst_control_cycle_counter #(
      .LEN (TIMEOUT_CYCLES)
    ) u_tmo_cnt (
      .clk      (clk),
      .rst      (rst),
      .clear    (tmo_clear_c),
      .enable   (state == ST_ACK),
      .expire_c (tmo_expire_c)
    );
  end else begin : g_no_tmo
    assign tmo_expire_c = 1'b0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and datapath strobes. Abort beats capture, capture beats timeout.
  always_comb begin
    state_nxt = state;
    start_c   = 1'b0;
    capture_c = 1'b0;
    commit_c  = 1'b0;
    tmo_set_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_s2) begin
          state_nxt = ST_NOTICE;
          start_c   = 1'b1;
        end
      end
      ST_NOTICE: begin
        if (!req_s2) begin
          state_nxt = ST_IDLE;
        end else if (notice_expire_c) begin
          state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!req_s2) begin
          state_nxt = ST_IDLE;
        end else if (valid_edge_c) begin
          capture_c = 1'b1;
          if (last_c) begin
            commit_c  = 1'b1;
            state_nxt = ST_DRAIN;
          end
        end else if (tmo_expire_c) begin
          tmo_set_c = 1'b1;
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!req_s2) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Shadow buffer with the incoming word merged at the current index.
  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < int'(BURST_LEN); i++) begin
      if (word_idx == IDX_W'(i)) begin
        shadow_nxt[i*DATA_W +: DATA_W] = din_s2;
      end
    end
  end

  // Registered outputs and burst storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack         <= 1'b0;
      notice      <= 1'b0;
      done        <= 1'b0;
      data        <= '0;
      shadow      <= '0;
      word_idx    <= '0;
      timeout_err <= 1'b0;
    end else begin
      ack    <= (state_nxt == ST_ACK);
      notice <= (state_nxt == ST_NOTICE);
      done   <= commit_c;
      if (start_c) begin
        shadow      <= '0;
        word_idx    <= '0;
        timeout_err <= 1'b0;
      end
      if (capture_c) begin
        shadow <= shadow_nxt;
        if (word_idx != IDX_W'(BURST_LEN)) begin
          word_idx <= word_idx + IDX_W'(1);
        end
      end
      if (commit_c) begin
        data <= shadow_nxt;
      end
      if (tmo_set_c) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_slave_burst_control.sv
// Self-checking bench for slave_burst_control: directed scenarios plus
// randomized bursts, compared every cycle against a transaction-level model.
module tb_slave_burst_control;

  localparam int DW  = 3;
  localparam int BL  = 4;
  localparam int NC  = 5;
  localparam int TC  = 20;
  localparam int BUS = DW * BL;
  localparam int IW  = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           request = 1'b0;
  logic           valid = 1'b0;
  logic [DW-1:0]  data_in = '0;
  logic           ack, notice, done, timeout_err;
  logic [BUS-1:0] data;
  logic [IW-1:0]  word_idx;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  slave_burst_control #(
    .DATA_W         (DW),
    .BURST_LEN      (BL),
    .NOTICE_CYCLES  (NC),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .request     (request),
    .valid       (valid),
    .data_in     (data_in),
    .ack         (ack),
    .notice      (notice),
    .data        (data),
    .done        (done),
    .word_idx    (word_idx),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The block acts on what the pins showed two edges earlier.
  typedef enum int {M_IDLE, M_NOTICE, M_ACK, M_DRAIN} mphase_t;
  mphase_t        m_phase = M_IDLE;
  int             m_left = 0;
  int             m_quiet = 0;
  logic [DW-1:0]  m_words[$];
  logic [BUS-1:0] m_data = '0;
  logic           m_done = 0, m_err = 0;
  int             m_idx = 0;
  logic           rq1 = 0, rq2 = 0, vl1 = 0, vl2 = 0, vl3 = 0;
  logic [DW-1:0]  dt1 = '0, dt2 = '0;

  function automatic logic [BUS-1:0] pack_words();
    logic [BUS-1:0] t;
    t = '0;
    for (int i = 0; i < m_words.size(); i++) t |= BUS'(m_words[i]) << (i * DW);
    return t;
  endfunction

  task automatic model_step();
    logic r, e;
    logic [DW-1:0] w;
    if (rst) begin
      m_phase = M_IDLE; m_left = 0; m_quiet = 0; m_words.delete();
      m_data = '0; m_done = 0; m_err = 0; m_idx = 0;
      rq1 = 0; rq2 = 0; vl1 = 0; vl2 = 0; vl3 = 0; dt1 = '0; dt2 = '0;
      return;
    end
    r = rq2; e = vl2 & ~vl3; w = dt2;
    vl3 = vl2; vl2 = vl1; vl1 = valid;
    rq2 = rq1; rq1 = request;
    dt2 = dt1; dt1 = data_in;
    m_done = 0;
    case (m_phase)
      M_IDLE: if (r) begin
        m_phase = M_NOTICE; m_left = NC; m_idx = 0; m_err = 0; m_words.delete();
      end
      M_NOTICE: if (!r) m_phase = M_IDLE;
      else begin
        m_left--;
        if (m_left == 0) begin m_phase = M_ACK; m_quiet = 0; end
      end
      M_ACK: if (!r) m_phase = M_IDLE;
      else if (e) begin
        m_words.push_back(w); m_idx++; m_quiet = 0;
        if (m_words.size() == BL) begin
          m_data = pack_words(); m_done = 1; m_phase = M_DRAIN;
        end
      end else begin
        m_quiet++;
        if (m_quiet == TC) begin m_err = 1; m_phase = M_DRAIN; end
      end
      M_DRAIN: if (!r) m_phase = M_IDLE;
      default: m_phase = M_IDLE;
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ack",         32'(ack),         32'(m_phase == M_ACK));
      check("notice",      32'(notice),      32'(m_phase == M_NOTICE));
      check("done",        32'(done),        32'(m_done));
      check("data",        32'(data),        32'(m_data));
      check("word_idx",    32'(word_idx),    32'(m_idx));
      check("timeout_err", 32'(timeout_err), 32'(m_err));
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int hi, input int lo);
    data_in = w; valid = 1'b1;
    tick(hi);
    valid = 1'b0;
    tick(lo);
  endtask

  task automatic wait_ack();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack) begin ok = 1; break; end
    end
    check("ack_wait_bound", 32'(ok), 32'd1);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    check("done_wait_bound", 32'(ok), 32'd1);
  endtask

  task automatic burst4(input logic [DW-1:0] w0, w1, w2, w3);
    send_word(w0, 1, 2);
    send_word(w1, 1, 2);
    send_word(w2, 1, 2);
    send_word(w3, 1, 0);
    wait_done();
    valid = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int mode, k;
    rst = 1'b1;
    tick(3);
    chk_en = 1'b1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_word_idx", 32'(word_idx), 32'd0);
    rst = 1'b0;
    tick(2);

    // 1: latency, notice length, basic burst
    request = 1'b1;
    tick(2);
    check("t1_notice_pre", 32'(notice), 32'd0);
    tick(1);
    check("t1_notice_edge3", 32'(notice), 32'd1);
    tick(4);
    check("t1_notice_last", 32'(notice), 32'd1);
    check("t1_ack_pre", 32'(ack), 32'd0);
    tick(1);
    check("t1_ack_up", 32'(ack), 32'd1);
    check("t1_notice_down", 32'(notice), 32'd0);
    burst4(3'd1, 3'd2, 3'd3, 3'd4);
    check("t1_data", 32'(data), 32'h8D1);
    check("t1_ack_off", 32'(ack), 32'd0);
    tick(1);
    check("t1_done_pulse", 32'(done), 32'd0);
    request = 1'b0;
    tick(4);

    // 2: valid held high captures exactly one word, then abort
    request = 1'b1;
    wait_ack();
    send_word(3'd5, 10, 4);
    check("t2_word_idx", 32'(word_idx), 32'd1);
    request = 1'b0;
    tick(4);
    check("t2_data_kept", 32'(data), 32'h8D1);

    // 3: stall after two words -> timeout exactly 20 cycles after last capture
    request = 1'b1;
    wait_ack();
    send_word(3'd6, 1, 2);
    send_word(3'd7, 1, 2);
    tick(19);
    check("t3_err_pre", 32'(timeout_err), 32'd0);
    tick(1);
    check("t3_err", 32'(timeout_err), 32'd1);
    check("t3_ack_off", 32'(ack), 32'd0);
    tick(5);
    check("t3_data_kept", 32'(data), 32'h8D1);
    request = 1'b0;
    tick(4);

    // 4: abort during notice
    request = 1'b1;
    tick(5);
    request = 1'b0;
    tick(6);
    check("t4_notice", 32'(notice), 32'd0);
    check("t4_ack", 32'(ack), 32'd0);
    check("t4_err_cleared", 32'(timeout_err), 32'd0);
    check("t4_data_kept", 32'(data), 32'h8D1);

    // 5: held request does not retrigger; re-request starts a new burst
    request = 1'b1;
    wait_ack();
    burst4(3'd6, 3'd1, 3'd4, 3'd3);
    check("t5_data", 32'(data), 32'h70E);
    tick(30);
    check("t5_no_notice", 32'(notice), 32'd0);
    check("t5_no_ack", 32'(ack), 32'd0);
    request = 1'b0;
    tick(4);
    request = 1'b1;
    wait_ack();
    burst4(3'(($urandom)), 3'(($urandom)), 3'(($urandom)), 3'(($urandom)));
    request = 1'b0;
    tick(4);

    // 6: reset mid-burst, then fresh burst
    request = 1'b1;
    wait_ack();
    send_word(3'd2, 1, 2);
    send_word(3'd3, 1, 2);
    rst = 1'b1; request = 1'b0;
    tick(1);
    check("t6_data0", 32'(data), 32'd0);
    check("t6_idx0", 32'(word_idx), 32'd0);
    check("t6_ack0", 32'(ack), 32'd0);
    rst = 1'b0;
    tick(2);
    request = 1'b1;
    wait_ack();
    burst4(3'd7, 3'd0, 3'd5, 3'd2);
    check("t6_data", 32'(data), 32'h547);
    request = 1'b0;
    tick(4);

    // randomized traffic with aborts, stalls and irregular strobes
    for (int it = 0; it < 30; it++) begin
      request = 1'b1;
      mode = $urandom_range(0, 7);
      if (mode == 7) begin
        tick($urandom_range(1, 7));
        request = 1'b0;
      end else begin
        wait_ack();
        k = (mode <= 1) ? $urandom_range(0, 3) : BL;
        for (int j = 0; j < k; j++)
          send_word(3'($urandom), $urandom_range(1, 3), $urandom_range(1, 5));
        if (mode == 1) tick(TC + 5);
        if (mode == 0) request = 1'b0;
        tick($urandom_range(0, 3));
        request = 1'b0;
      end
      tick($urandom_range(3, 6));
    end

    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
